// File: rtl/simmem_write_resp_bank_pkg.sv
// rtl/simmem_write_resp_bank_pkg.sv - shared types and sizes for the write response bank
// Purpose: widths, the write_resp_t record and pointer/count types used by the bank,
//          its interface and its arbiter.
// Ports:   none (package).
package simmem_write_resp_bank_pkg;

    localparam int NumIds                     = 16;
    localparam int IDWidth                    = $clog2(NumIds);
    localparam int WriteRespBankTotalCapacity = 32;
    localparam int WriteRespBankAddrWidth     = $clog2(WriteRespBankTotalCapacity);
    localparam int RespContentWidth           = 8;

    typedef logic [IDWidth-1:0]                id_t;
    typedef logic [WriteRespBankAddrWidth-1:0] wresp_bank_ptr_t;
    // One extra bit so a completely full bank (Capacity) is representable.
    typedef logic [WriteRespBankAddrWidth:0]   wresp_bank_cnt_t;

    typedef struct packed {
        id_t                         id;
        logic [RespContentWidth-1:0] content;
    } write_resp_t;

    localparam int WriteRespWidth = $bits(write_resp_t);

endpackage

// File: rtl/simmem_write_resp_bank_if.sv
// rtl/simmem_write_resp_bank_if.sv - B-channel side bundle of the write response bank
// Purpose: groups the slave-side input stream, release vector, requester-side output
//          stream and occupancy of the bank.
// Ports:   slave modport (bank): in_valid_i/in_data_i/release_en_i/out_ready_i in,
//          in_ready_o/out_valid_o/out_data_o/occupancy_o out; master modport is the mirror.
interface simmem_write_resp_bank_if;
    import simmem_write_resp_bank_pkg::*;

    logic              in_valid_i;
    logic              in_ready_o;
    write_resp_t       in_data_i;
    logic [NumIds-1:0] release_en_i;
    logic              out_valid_o;
    logic              out_ready_i;
    write_resp_t       out_data_o;
    wresp_bank_cnt_t   occupancy_o;

    modport slave (
        input  in_valid_i, in_data_i, release_en_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, occupancy_o
    );

    modport master (
        output in_valid_i, in_data_i, release_en_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, occupancy_o
    );

endinterface

// File: rtl/simmem_write_resp_bank_id_arbiter.sv
// rtl/simmem_write_resp_bank_id_arbiter.sv - priority / round-robin request picker
// Purpose: picks one set bit of i_req. With RrEn the search starts at i_rr_ptr and wraps,
//          otherwise the lowest index wins. N must be a power of two.
// Ports:   i_req (N) requests, i_rr_ptr start index, o_grant one-hot, o_idx index,
//          o_valid any request set.
module simmem_id_arbiter #(
    parameter int N    = 16,
    parameter bit RrEn = 1'b0,
    localparam int W   = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_rr_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);

    logic [W-1:0] w_start;
    logic [W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_start = RrEn ? i_rr_ptr : '0;
        w_cand  = '0;
        // Index arithmetic wraps naturally at N because N is a power of two.
        for (int k = 0; k < N; k++) begin
            w_cand = w_start + W'(k);
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simmem_write_resp_bank.sv
// rtl/simmem_write_resp_bank.sv - per-ID linked-list buffer for AXI write responses
// Purpose: stores responses from the memory slave in a shared pool, one linked list per ID,
//          and emits the head of a released ID. Define SIMMEM_WRESP_BANK_RR_EN for
//          round-robin selection between released IDs; default is lowest ID first.
// Ports:   clk_i clock, rst_i async active-high reset,
//          bus (slave modport): input stream, release_en_i, output stream, occupancy_o.
module simmem_write_resp_bank
    import simmem_write_resp_bank_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    simmem_write_resp_bank_if.slave  bus
);

    localparam int Capacity = WriteRespBankTotalCapacity;
`ifdef SIMMEM_WRESP_BANK_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    write_resp_t     r_data  [Capacity];
    wresp_bank_ptr_t r_next  [Capacity];
    wresp_bank_ptr_t r_head  [NumIds];
    wresp_bank_ptr_t r_tail  [NumIds];
    wresp_bank_cnt_t r_count [NumIds];
    logic [Capacity-1:0] r_free;
    wresp_bank_cnt_t     r_occupancy;
    logic                r_lock;
    id_t                 r_lock_id;

    logic [Capacity-1:0] w_free_grant;
    logic [Capacity-1:0] w_free_nxt;
    wresp_bank_ptr_t     w_free_ptr;
    logic                w_free_any;
    logic [NumIds-1:0]   w_elig;
    logic [NumIds-1:0]   w_arb_grant;
    id_t                 w_arb_idx;
    logic                w_arb_valid;
    logic                w_locked;
    id_t                 w_sel;
    logic [NumIds-1:0]   w_sel_oh;
    id_t                 w_rr_ptr;
    logic                w_push;
    logic                w_pop;
    logic [NumIds-1:0]   w_push_hit;
    logic [NumIds-1:0]   w_pop_hit;
    wresp_bank_ptr_t     w_head_sel;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NumIds; i++) begin
            w_elig[i] = bus.release_en_i[i] && (r_count[i] != '0);
        end
    end

    simmem_id_arbiter #(.N(Capacity), .RrEn(1'b0)) u_free_search (
        .i_req    (r_free),
        .i_rr_ptr ('0),
        .o_grant  (w_free_grant),
        .o_idx    (w_free_ptr),
        .o_valid  (w_free_any)
    );

    simmem_id_arbiter #(.N(NumIds), .RrEn(RrEn)) u_id_arb (
        .i_req    (w_elig),
        .i_rr_ptr (w_rr_ptr),
        .o_grant  (w_arb_grant),
        .o_idx    (w_arb_idx),
        .o_valid  (w_arb_valid)
    );

    // A presented response stays selected until accepted, even if a higher-priority ID
    // becomes eligible meanwhile, so out_data_o cannot change under a stalled valid.
    assign w_locked   = r_lock && w_elig[r_lock_id];
    assign w_sel      = w_locked ? r_lock_id : w_arb_idx;
    assign w_sel_oh   = w_locked ? (NumIds'(1) << r_lock_id) : w_arb_grant;
    assign w_head_sel = r_head[w_sel];

    assign bus.in_ready_o  = (r_occupancy != wresp_bank_cnt_t'(Capacity));
    assign bus.out_valid_o = w_arb_valid;
    assign bus.out_data_o  = w_arb_valid ? r_data[w_head_sel] : '0;
    assign bus.occupancy_o = r_occupancy;

    assign w_push = bus.in_valid_i && bus.in_ready_o && w_free_any;
    assign w_pop  = w_arb_valid && bus.out_ready_i;

    always_comb begin
        w_push_hit = '0;
        w_pop_hit  = '0;
        for (int i = 0; i < NumIds; i++) begin
            w_push_hit[i] = w_push && (bus.in_data_i.id == id_t'(i));
            w_pop_hit[i]  = w_pop && w_sel_oh[i];
        end
        // The popped entry is still marked busy here, so the push can never take it.
        w_free_nxt = r_free;
        if (w_push) w_free_nxt = w_free_nxt & ~w_free_grant;
        if (w_pop)  w_free_nxt[w_head_sel] = 1'b1;
    end

`ifdef SIMMEM_WRESP_BANK_RR_EN
    id_t r_rr_ptr;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      r_rr_ptr <= '0;
        else if (w_pop) r_rr_ptr <= w_sel + id_t'(1);
    end
    assign w_rr_ptr = r_rr_ptr;
`else
    assign w_rr_ptr = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_free      <= '1;
            r_occupancy <= '0;
            r_lock      <= 1'b0;
            r_lock_id   <= '0;
            for (int i = 0; i < NumIds; i++) r_count[i] <= '0;
        end else begin
            r_free      <= w_free_nxt;
            r_occupancy <= r_occupancy + wresp_bank_cnt_t'(w_push) - wresp_bank_cnt_t'(w_pop);
            r_lock      <= w_arb_valid && !bus.out_ready_i;
            r_lock_id   <= w_sel;
            for (int i = 0; i < NumIds; i++) begin
                r_count[i] <= r_count[i] + wresp_bank_cnt_t'(w_push_hit[i])
                                         - wresp_bank_cnt_t'(w_pop_hit[i]);
            end
        end
    end

    // Storage and list pointers are only meaningful while their count is non-zero.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_data[w_free_ptr] <= bus.in_data_i;
            if (r_count[bus.in_data_i.id] != '0) r_next[r_tail[bus.in_data_i.id]] <= w_free_ptr;
        end
        for (int i = 0; i < NumIds; i++) begin
            if (w_push_hit[i] && ((r_count[i] == '0) ||
                                  (w_pop_hit[i] && r_count[i] == wresp_bank_cnt_t'(1)))) begin
                r_head[i] <= w_free_ptr;
            end else if (w_pop_hit[i]) begin
                r_head[i] <= r_next[r_head[i]];
            end
            if (w_push_hit[i]) r_tail[i] <= w_free_ptr;
        end
    end

endmodule

// File: tb/tb_simmem_write_resp_bank.sv
// tb/tb_simmem_write_resp_bank.sv - directed self-checking bench for simmem_write_resp_bank
module tb_simmem_write_resp_bank;
    import simmem_write_resp_bank_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    simmem_write_resp_bank_if bus();

    simmem_write_resp_bank dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int id, input int c);
        return {20'd0, id[3:0], c[7:0]};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input int id, input int c);
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = write_resp_t'(mk(id, c));
        step();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic expect_pop(input string tag, input int id, input int c);
        bus.out_ready_i = 1'b1;
        #1;
        check_eq({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
        check_eq(tag, 32'(bus.out_data_o), mk(id, c));
        step();
        bus.out_ready_i = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
    endtask

    int exp_id [6];
    int exp_c  [6];
    int pops;
    int sum;

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.in_valid_i   = 1'b0;
        bus.in_data_i    = '0;
        bus.release_en_i = '0;
        bus.out_ready_i  = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        #1;
        check_eq("rst_in_ready",  32'(bus.in_ready_o),  32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        check_eq("rst_occ",       32'(bus.occupancy_o), 32'd0);
        check_eq("rst_out_data",  32'(bus.out_data_o),  32'd0);

        // Reset in the middle of traffic
        push(3, 9);
        push(6, 4);
        bus.release_en_i = 16'h0008;
        #1;
        check_eq("mid_valid_pre", 32'(bus.out_valid_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
        check_eq("mid_rst_ready", 32'(bus.in_ready_o),  32'd1);
        check_eq("mid_rst_occ",   32'(bus.occupancy_o), 32'd0);
        check_eq("mid_rst_data",  32'(bus.out_data_o),  32'd0);
        step();
        rst_i = 1'b0;
        bus.release_en_i = '0;

        // Per-ID order
        push(3, 1);
        push(3, 2);
        push(3, 5);
        #1;
        check_eq("order_occ", 32'(bus.occupancy_o), 32'd3);
        bus.release_en_i = 16'h0008;
        expect_pop("order_0", 3, 1);
        expect_pop("order_1", 3, 2);
        expect_pop("order_2", 3, 5);
        #1;
        check_eq("order_empty_valid", 32'(bus.out_valid_o), 32'd0);
        check_eq("order_empty_occ",   32'(bus.occupancy_o), 32'd0);

        // Different IDs overtake each other
        bus.release_en_i = '0;
        push(1, 2);
        push(4, 0);
        bus.release_en_i = 16'h0010;
        expect_pop("overtake_id4", 4, 0);
        #1;
        check_eq("overtake_id1_held", 32'(bus.out_valid_o), 32'd0);
        bus.release_en_i = 16'h0012;
        expect_pop("overtake_id1", 1, 2);
        bus.release_en_i = '0;

        // Same-ID push and pop with a single entry
        push(7, 'hA);
        bus.in_valid_i   = 1'b1;
        bus.in_data_i    = write_resp_t'(mk(7, 'hB));
        bus.release_en_i = 16'h0080;
        bus.out_ready_i  = 1'b1;
        #1;
        check_eq("same_id_out_old", 32'(bus.out_data_o), mk(7, 'hA));
        step();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        #1;
        check_eq("same_id_occ",      32'(bus.occupancy_o), 32'd1);
        check_eq("same_id_head_new", 32'(bus.out_data_o),  mk(7, 'hB));
        expect_pop("same_id_pop", 7, 'hB);
        bus.release_en_i = '0;

        // Backpressure: output must hold while not accepted
        push(2, 'h33);
        bus.release_en_i = 16'h0004;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                bus.in_valid_i = 1'b1;
                bus.in_data_i  = write_resp_t'(mk(2, 'h44));
            end else begin
                bus.in_valid_i = 1'b0;
            end
            #1;
            check_eq("bp_valid", 32'(bus.out_valid_o), 32'd1);
            check_eq("bp_data",  32'(bus.out_data_o),  mk(2, 'h33));
            step();
        end
        bus.in_valid_i = 1'b0;
        expect_pop("bp_pop0", 2, 'h33);
        expect_pop("bp_pop1", 2, 'h44);
        bus.release_en_i = '0;

        // Fill the bank completely, then push+pop while full
        for (int i = 0; i < 32; i++) push(i % 16, i);
        #1;
        check_eq("full_ready", 32'(bus.in_ready_o),  32'd0);
        check_eq("full_occ",   32'(bus.occupancy_o), 32'd32);
        bus.in_valid_i   = 1'b1;
        bus.in_data_i    = write_resp_t'(mk(0, 'hFF));
        bus.release_en_i = 16'h0001;
        bus.out_ready_i  = 1'b1;
        #1;
        check_eq("full_pop_data", 32'(bus.out_data_o), mk(0, 0));
        check_eq("full_pop_ready", 32'(bus.in_ready_o), 32'd0);
        step();
        bus.in_valid_i   = 1'b0;
        bus.release_en_i = '0;
        bus.out_ready_i  = 1'b0;
        #1;
        check_eq("full_after_occ",   32'(bus.occupancy_o), 32'd31);
        check_eq("full_after_ready", 32'(bus.in_ready_o),  32'd1);
        bus.release_en_i = 16'hFFFF;
        bus.out_ready_i  = 1'b1;
        pops = 0;
        sum  = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (bus.out_valid_o) begin
                pops++;
                sum += int'(bus.out_data_o.content);
            end
            step();
        end
        bus.out_ready_i  = 1'b0;
        bus.release_en_i = '0;
        check_eq("drain_pops", pops, 32'd31);
        check_eq("drain_sum",  sum,  32'd496);
        check_eq("drain_occ",  32'(bus.occupancy_o), 32'd0);

        // Arbitration between IDs 0, 2, 5
        pulse_reset();
        push(0, 1);
        push(0, 2);
        push(2, 3);
        push(2, 4);
        push(5, 5);
        push(5, 6);
`ifdef SIMMEM_WRESP_BANK_RR_EN
        exp_id = '{0, 2, 5, 0, 2, 5};
        exp_c  = '{1, 3, 5, 2, 4, 6};
`else
        exp_id = '{0, 0, 2, 2, 5, 5};
        exp_c  = '{1, 2, 3, 4, 5, 6};
`endif
        bus.release_en_i = 16'hFFFF;
        for (int k = 0; k < 6; k++) expect_pop($sformatf("arb_%0d", k), exp_id[k], exp_c[k]);
        #1;
        check_eq("arb_done_valid", 32'(bus.out_valid_o), 32'd0);
        bus.release_en_i = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
